// File: rtl/ahbl_gpio_ctrl.sv
// AHB-Lite register block for a 16-bit GPIO pad wrapper: output/direction/pull controls,
// synchronized pad input with per-bit edge detection and a maskable W1C interrupt status.
module ahbl_gpio_ctrl #(
    parameter int unsigned NBITS = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic             HREADY,
    input  logic [31:0]      HWDATA,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [NBITS-1:0] WGPIODIN,
    output logic [NBITS-1:0] WGPIODOUT,
    output logic [NBITS-1:0] WGPIODIR,
    output logic [NBITS-1:0] WGPIOPU,
    output logic [NBITS-1:0] WGPIOPD,
    output logic             IRQ
);

    localparam int unsigned AW     = 3;
    localparam int unsigned DW     = 32;
    localparam int unsigned WARM_W = 2;

    localparam logic [AW-1:0] A_DATAIN  = AW'(0);
    localparam logic [AW-1:0] A_DATAOUT = AW'(1);
    localparam logic [AW-1:0] A_DIR     = AW'(2);
    localparam logic [AW-1:0] A_PU      = AW'(3);
    localparam logic [AW-1:0] A_PD      = AW'(4);
    localparam logic [AW-1:0] A_IM      = AW'(5);
    localparam logic [AW-1:0] A_POL     = AW'(6);
    localparam logic [AW-1:0] A_IS      = AW'(7);

    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(3);

    logic              valid_q, valid_d;
    logic              write_q, write_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [NBITS-1:0]  dout_q, dout_d;
    logic [NBITS-1:0]  dir_q, dir_d;
    logic [NBITS-1:0]  pu_q, pu_d;
    logic [NBITS-1:0]  pd_q, pd_d;
    logic [NBITS-1:0]  im_q, im_d;
    logic [NBITS-1:0]  pol_q, pol_d;
    logic [NBITS-1:0]  is_q, is_d;
    logic [NBITS-1:0]  s1_q, s2_q, s3_q;
    logic [WARM_W-1:0] warm_q, warm_d;

    logic              wr_en;
    logic [NBITS-1:0]  wdata;
    logic [NBITS-1:0]  w1c;
    logic [NBITS-1:0]  edge_det;
    logic [NBITS-1:0]  rdata;

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[DW-1:NBITS]};

    // Address-phase capture, register writes, edge detection and IS update
    always_comb begin
        valid_d = HSEL & HTRANS[1] & HREADY;
        write_d = HWRITE;
        addr_d  = HADDR[4:2];
        wr_en   = valid_q & write_q;
        wdata   = HWDATA[NBITS-1:0];
        dout_d  = dout_q;
        dir_d   = dir_q;
        pu_d    = pu_q;
        pd_d    = pd_q;
        im_d    = im_q;
        pol_d   = pol_q;
        w1c     = '0;
        if (wr_en) begin
            case (addr_q)
                A_DATAOUT: dout_d = wdata;
                A_DIR:     dir_d  = wdata;
                A_PU:      pu_d   = wdata;
                A_PD:      pd_d   = wdata;
                A_IM:      im_d   = wdata;
                A_POL:     pol_d  = wdata;
                A_IS:      w1c    = wdata;
                default:   ;
            endcase
        end
        warm_d   = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);
        edge_det = (pol_q & s2_q & ~s3_q) | (~pol_q & ~s2_q & s3_q);
        if (warm_q != WARM_DONE) begin
            edge_det = '0;
        end
        // A new edge takes priority over a same-cycle clear
        is_d = edge_det | (is_q & ~w1c);
    end

    // Read mux, driven only during a read data phase
    always_comb begin
        rdata = '0;
        case (addr_q)
            A_DATAIN:  rdata = s2_q;
            A_DATAOUT: rdata = dout_q;
            A_DIR:     rdata = dir_q;
            A_PU:      rdata = pu_q;
            A_PD:      rdata = pd_q;
            A_IM:      rdata = im_q;
            A_POL:     rdata = pol_q;
            A_IS:      rdata = is_q;
            default:   rdata = '0;
        endcase
        HRDATA = (valid_q & ~write_q) ? DW'(rdata) : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            dir_q   <= '0;
            pu_q    <= '0;
            pd_q    <= '0;
            im_q    <= '0;
            pol_q   <= '0;
            is_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            warm_q  <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
            im_q    <= im_d;
            pol_q   <= pol_d;
            is_q    <= is_d;
            s1_q    <= WGPIODIN;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            warm_q  <= warm_d;
        end
    end

    assign WGPIODOUT = dout_q;
    assign WGPIODIR  = dir_q;
    assign WGPIOPU   = pu_q;
    assign WGPIOPD   = pd_q;
    assign IRQ       = |(is_q & im_q);
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahbl_gpio_ctrl.sv
// Self-checking bench for ahbl_gpio_ctrl; read expectations are queued at the address
// phase and compared when the data phase returns HRDATA.
module tb_ahbl_gpio_ctrl;

    localparam int unsigned NBITS = 16;

    localparam logic [31:0] R_DATAIN  = 32'h00;
    localparam logic [31:0] R_DATAOUT = 32'h04;
    localparam logic [31:0] R_DIR     = 32'h08;
    localparam logic [31:0] R_PU      = 32'h0C;
    localparam logic [31:0] R_PD      = 32'h10;
    localparam logic [31:0] R_IM      = 32'h14;
    localparam logic [31:0] R_POL     = 32'h18;
    localparam logic [31:0] R_IS      = 32'h1C;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             HSEL;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic             HREADY;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADYOUT;
    logic             HRESP;
    logic [NBITS-1:0] WGPIODIN;
    logic [NBITS-1:0] WGPIODOUT;
    logic [NBITS-1:0] WGPIODIR;
    logic [NBITS-1:0] WGPIOPU;
    logic [NBITS-1:0] WGPIOPD;
    logic             IRQ;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    ahbl_gpio_ctrl #(.NBITS(NBITS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .WGPIODIN(WGPIODIN), .WGPIODOUT(WGPIODOUT),
        .WGPIODIR(WGPIODIR), .WGPIOPU(WGPIOPU), .WGPIOPD(WGPIOPD), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Address phase now, data phase after next negedge; returns inside the data phase
    task automatic ahb_raw_write(input logic sel, input logic [1:0] trans,
                                 input logic [31:0] a, input logic [31:0] d);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = 1'b1;
        HADDR  = a;
        @(negedge HCLK);
        bus_idle();
        HWDATA = d;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        ahb_raw_write(1'b1, 2'b10, a, d);
    endtask

    task automatic ahb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = a;
        exp_q.push_back(exp);
        @(negedge HCLK);
        bus_idle();
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, HRDATA, e);
        end
    endtask

    initial begin
        HRESETn  = 1'b0;
        HSIZE    = 3'b010;
        HREADY   = 1'b1;
        HADDR    = '0;
        HWDATA   = '0;
        WGPIODIN = '0;
        bus_idle();

        // Reset values
        tick(2);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_hresp", 32'(HRESP), 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_dout", 32'(WGPIODOUT), 32'h0);
        check("rst_dir", 32'(WGPIODIR), 32'h0);
        HRESETn = 1'b1;
        tick(2);
        check("post_rst_pu", 32'(WGPIOPU), 32'h0);
        check("post_rst_pd", 32'(WGPIOPD), 32'h0);
        check("post_rst_hrdata", HRDATA, 32'h0);

        // Register writes drive the wrapper outputs; upper HWDATA bits dropped
        ahb_write(R_DATAOUT, 32'hFFFF_00A5);
        tick(1);
        check("dout_a5", 32'(WGPIODOUT), 32'h00A5);
        ahb_write(R_DIR, 32'h0000_FFFF);
        tick(1);
        check("dir_ffff", 32'(WGPIODIR), 32'hFFFF);
        ahb_read("rd_dout", R_DATAOUT, 32'h0000_00A5);
        ahb_read("rd_dir", R_DIR, 32'h0000_FFFF);
        ahb_write(R_PU, 32'h0000_0F0F);
        ahb_write(R_PD, 32'h0000_F0F0);
        tick(1);
        check("pu", 32'(WGPIOPU), 32'h0F0F);
        check("pd", 32'(WGPIOPD), 32'hF0F0);
        // Back-to-back write then read of the same register
        ahb_write(R_DATAOUT, 32'h0000_5A5A);
        ahb_read("b2b_dout", R_DATAOUT, 32'h0000_5A5A);
        ahb_read("rd_pd", R_PD, 32'h0000_F0F0);

        // Input synchronizer latency: one edge is too early, two edges shows the value
        WGPIODIN = 16'h1234;
        ahb_read("sync_1edge", R_DATAIN, 32'h0);
        ahb_read("sync_2edge", R_DATAIN, 32'h1234);

        // Rising edge on bit 0 with IM bit 0 set
        ahb_write(R_POL, 32'hFFFF);
        ahb_write(R_IM, 32'h0001);
        tick(2);
        WGPIODIN = 16'h1235;
        tick(2);
        check("rise_irq_k1", 32'(IRQ), 32'h0);
        tick(1);
        check("rise_irq_k2", 32'(IRQ), 32'h1);
        ahb_read("rise_is", R_IS, 32'h0001);
        ahb_write(R_IS, 32'h0001);
        tick(1);
        check("rise_irq_clr", 32'(IRQ), 32'h0);
        ahb_read("rise_is_clr", R_IS, 32'h0);

        // Falling edge on bit 3, masked then unmasked
        ahb_write(R_POL, 32'h0000);
        ahb_write(R_IM, 32'h0000);
        tick(2);
        WGPIODIN = 16'h123D;
        tick(4);
        ahb_read("fall_rise_ignored", R_IS, 32'h0);
        WGPIODIN = 16'h1235;
        tick(3);
        ahb_read("fall_is", R_IS, 32'h0008);
        check("fall_irq_masked", 32'(IRQ), 32'h0);
        ahb_write(R_IM, 32'h0008);
        tick(1);
        check("fall_irq_unmasked", 32'(IRQ), 32'h1);
        ahb_write(R_IS, 32'h0008);
        tick(1);
        check("fall_irq_clr", 32'(IRQ), 32'h0);

        // W1C of bit 0 lands on the same edge that sets it again
        ahb_write(R_POL, 32'hFFFF);
        ahb_write(R_IM, 32'h0001);
        tick(2);
        WGPIODIN = 16'h1234;
        tick(3);
        WGPIODIN = 16'h1235;
        tick(3);
        ahb_read("coll_pre_is", R_IS, 32'h0001);
        WGPIODIN = 16'h1234;
        tick(3);
        WGPIODIN = 16'h1235;
        tick(1);
        ahb_write(R_IS, 32'h0001);
        ahb_read("coll_set_wins", R_IS, 32'h0001);
        check("coll_irq", 32'(IRQ), 32'h1);
        ahb_write(R_IS, 32'h0001);
        ahb_read("coll_clr_after", R_IS, 32'h0);

        // Reset during a write data phase discards the write
        ahb_write(R_DATAOUT, 32'h1111);
        HRESETn  = 1'b0;
        WGPIODIN = 16'hFFFF;
        tick(1);
        check("midrst_dout", 32'(WGPIODOUT), 32'h0);
        check("midrst_irq", 32'(IRQ), 32'h0);
        tick(2);

        // Warm-up: pins held high through release, POL set to rising as early as possible
        HRESETn = 1'b1;
        ahb_write(R_POL, 32'hFFFF);
        ahb_write(R_IM, 32'hFFFF);
        tick(6);
        check("warm_irq", 32'(IRQ), 32'h0);
        ahb_read("warm_is", R_IS, 32'h0);
        check("warm_dout", 32'(WGPIODOUT), 32'h0);

        // Address wrap and ignored writes
        ahb_read("wrap_0x20", 32'h20, 32'hFFFF);
        ahb_write(R_DATAIN, 32'hBEEF);
        ahb_raw_write(1'b0, 2'b10, R_DATAOUT, 32'h1357);
        ahb_raw_write(1'b1, 2'b01, R_DIR, 32'h2468);
        tick(1);
        ahb_read("ro_datain", R_DATAIN, 32'hFFFF);
        ahb_read("nosel_dout", R_DATAOUT, 32'h0);
        ahb_read("busy_dir", R_DIR, 32'h0);
        ahb_read("keep_pol", R_POL, 32'hFFFF);
        ahb_read("keep_im", R_IM, 32'hFFFF);
        check("end_irq", 32'(IRQ), 32'h0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
